// File: rtl/p1p2_arb_pkg.sv
// Shared types for the two-requester arbiter: state encoding, default hold limit,
// and the priority pick used whenever the resource is free.
package p1p2_arb_pkg;

  localparam int HOLD_MAX_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_G1   = 3'd1,
    S_G2   = 3'd2,
    S_REL  = 3'd3,
    S_TMO  = 3'd4
  } state_t;

  // ptr=0 favours P1 on contention, ptr=1 favours P2
  function automatic state_t arb_pick(input logic p1, input logic p2, input logic ptr);
    state_t s;
    s = S_IDLE;
    if (p1 && !p2)      s = S_G1;
    else if (!p1 && p2) s = S_G2;
    else if (p1 && p2)  s = ptr ? S_G2 : S_G1;
    return s;
  endfunction

endpackage

// File: rtl/p1p2_arbiter.sv
// Moore two-requester arbiter: round-robin on contention, forced release after
// HOLD_MAX grant cycles, one dead cycle (REL/TMO) between any two grants.
module p1p2_arbiter
  import p1p2_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic P1,
  input  logic P2,
  output logic g1,
  output logic g2,
  output logic z,
  output logic tmo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic             ptr, nxt_ptr;

  always_comb begin
    nxt     = state;
    nxt_ptr = ptr;
    case (state)
      S_IDLE, S_REL, S_TMO: nxt = arb_pick(P1, P2, ptr);
      S_G1: begin
        if (!P1) begin
          nxt     = S_REL;
          nxt_ptr = 1'b1;
        end else if (hold_cnt == CNT_LAST) begin
          nxt     = S_TMO;
          nxt_ptr = 1'b1;
        end
      end
      S_G2: begin
        if (!P2) begin
          nxt     = S_REL;
          nxt_ptr = 1'b0;
        end else if (hold_cnt == CNT_LAST) begin
          nxt     = S_TMO;
          nxt_ptr = 1'b0;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they always equal the decode of state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= 1'b0;
      g1    <= 1'b0;
      g2    <= 1'b0;
      z     <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= nxt;
      ptr   <= nxt_ptr;
      g1    <= (nxt == S_G1);
      g2    <= (nxt == S_G2);
      z     <= (nxt == S_G1) || (nxt == S_G2);
      tmo   <= (nxt == S_TMO);
    end
  end

  // A grant is always preceded by a non-grant state, so state != nxt marks entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (nxt == S_G1 || nxt == S_G2) begin
      if (nxt != state)              hold_cnt <= '0;
      else if (hold_cnt != CNT_LAST) hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_p1p2_arbiter.sv
// Directed bench for p1p2_arbiter: a vector table for the main flows plus hand
// sequences for reset-mid-grant and idle stability.
module tb_p1p2_arbiter;
  import p1p2_arb_pkg::*;

  logic clk = 1'b0;
  logic reset, P1, P2;
  logic g1, g2, z, tmo;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  p1p2_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .P1(P1), .P2(P2),
    .g1(g1), .g2(g2), .z(z), .tmo(tmo)
  );

  typedef struct {
    logic       rst;
    logic       p1;
    logic       p2;
    logic [3:0] exp;   // {g1, g2, z, tmo}
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic a, logic b, logic [3:0] e, string n);
    vec_t v;
    v.rst = r; v.p1 = a; v.p2 = b; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got g1g2ztmo=%b want %b", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, sample just after the edge.
  task automatic step(logic r, logic a, logic b, logic [3:0] exp, string name);
    reset = r; P1 = a; P2 = b;
    @(posedge clk);
    #1;
    chk(name, {g1, g2, z, tmo}, exp);
    checks++;
    if (g1 && g2) begin
      errors++;
      $display("FAIL %s_excl: got g1=%b g2=%b want not both", name, g1, g2);
    end
  endtask

  initial begin
    reset = 1'b1; P1 = 1'b0; P2 = 1'b0;

    // single request and release, back-to-back same requester
    tbl.push_back(mk(1, 0, 0, 4'b0000, "rst"));
    tbl.push_back(mk(0, 1, 0, 4'b1010, "single_g1a"));
    tbl.push_back(mk(0, 1, 0, 4'b1010, "single_g1b"));
    tbl.push_back(mk(0, 0, 0, 4'b0000, "single_rel"));
    tbl.push_back(mk(0, 0, 0, 4'b0000, "single_idle"));
    tbl.push_back(mk(0, 1, 0, 4'b1010, "b2b_g1a"));
    tbl.push_back(mk(0, 0, 0, 4'b0000, "b2b_rel"));
    tbl.push_back(mk(0, 1, 0, 4'b1010, "b2b_g1b"));
    tbl.push_back(mk(0, 0, 0, 4'b0000, "b2b_rel2"));
    // contention after reset: P1 first, timeout, P2, timeout, P1
    tbl.push_back(mk(1, 0, 0, 4'b0000, "rst2"));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 4'b1010, "cont_g1"));
    tbl.push_back(mk(0, 1, 1, 4'b0001, "cont_tmo1"));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 4'b0110, "cont_g2"));
    tbl.push_back(mk(0, 1, 1, 4'b0001, "cont_tmo2"));
    tbl.push_back(mk(0, 1, 1, 4'b1010, "cont_g1_again"));
    // round-robin on release: P1 drops, then re-asserts, but P2 wins
    tbl.push_back(mk(0, 0, 1, 4'b0000, "rr_rel"));
    tbl.push_back(mk(0, 1, 1, 4'b0110, "rr_g2"));
    tbl.push_back(mk(0, 0, 0, 4'b0000, "rr_rel2"));
    tbl.push_back(mk(0, 0, 0, 4'b0000, "rr_idle"));
    // timeout alone: P2 held 10 cycles
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 4'b0110, "solo_g2a"));
    tbl.push_back(mk(0, 0, 1, 4'b0001, "solo_tmo1"));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 4'b0110, "solo_g2b"));
    tbl.push_back(mk(0, 0, 1, 4'b0001, "solo_tmo2"));
    tbl.push_back(mk(0, 0, 0, 4'b0000, "solo_idle"));

    @(negedge clk);
    foreach (tbl[i]) step(tbl[i].rst, tbl[i].p1, tbl[i].p2, tbl[i].exp, tbl[i].name);

    // reset mid-grant, then a fresh full-length grant
    step(1, 0, 0, 4'b0000, "mid_rst0");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'b1010, "mid_g1");
    step(1, 1, 0, 4'b0000, "mid_rst");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 4'b1010, "post_rst_g1");
    step(0, 1, 0, 4'b0001, "post_rst_tmo");
    step(0, 1, 0, 4'b1010, "post_rst_regrant");

    // idle stability
    step(1, 0, 0, 4'b0000, "idle_rst");
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 4'b0000, "idle_out");
      checks++;
      if (dut.state !== S_IDLE) begin
        errors++;
        $display("FAIL idle_state: got %0d want %0d", dut.state, S_IDLE);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
